// File: rtl/mux16_arb_pkg.sv
// mux16_arb_pkg: shared widths and FSM state encoding for the 16-way round-robin mux arbiter
package mux16_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int SEL_W = 4;
  localparam int HOLD_W = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} arb_state_t;
endpackage

// File: rtl/mux16_rr_arbiter_if.sv
// mux16_rr_arbiter_if: requester/consumer bus of the arbiter
//   req, data_in : per-channel request level and data bit (driven by master)
//   gnt, sel     : one-hot grant and held 4-bit select (driven by slave)
//   data_o       : registered data_in[sel]
//   busy, tmo_o  : grant active, forced-release pulse
interface mux16_rr_arbiter_if;
  import mux16_arb_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] data_in;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic data_o;
  logic busy;
  logic tmo_o;
  modport master (output req, data_in, input gnt, sel, data_o, busy, tmo_o);
  modport slave (input req, data_in, output gnt, sel, data_o, busy, tmo_o);
endinterface

// File: rtl/mux16_rr_arbiter_pick.sv
// rr_pick16: combinational round-robin pick of the first set req bit starting at ptr
//   req : request vector    ptr : highest-priority index
//   idx : chosen index      any : some request is set
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0] k;
  // rotate so ptr lands at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) k = rot[i] ? SEL_W'(i) : k;
    idx = k + ptr;
    any = |req;
  end
endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter owning a 16:1 bit-select mux with registered output
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   b     : mux16_rr_arbiter_if.slave (req, data_in in; gnt, sel, data_o, busy, tmo_o out)
//   Optional macro MUX16_ARB_TIMEOUT_EN: forces release after MAX_HOLD grant cycles.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input logic clk,
  input logic rst_n,
  mux16_rr_arbiter_if.slave b
);
  if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_hold
    $error("MAX_HOLD out of range");
  end
  arb_state_t state, nxt;
  logic [SEL_W-1:0] sel, ptr, idx;
  logic any, data_q, tmo, hold_hit;
  rr_pick16 u_pick (.req(b.req), .ptr(ptr), .idx(idx), .any(any));
`ifdef MUX16_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt <= '0;
    else hold_cnt <= state == ST_GRANT ? hold_cnt + 1'b1 : '0;
  assign hold_hit = hold_cnt == HOLD_W'(MAX_HOLD - 1);
`else
  assign hold_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= nxt;
  // GAP and the unused code both fall back to IDLE
  always_comb
    nxt = state == ST_IDLE  ? (any ? ST_GRANT : ST_IDLE) :
          state == ST_GRANT ? ((!b.req[sel] || hold_hit) ? ST_GAP : ST_GRANT) :
          ST_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sel <= '0;
      ptr <= '0;
      data_q <= 1'b0;
      tmo <= 1'b0;
    end else begin
      if (state == ST_IDLE && any) sel <= idx;
      if (state == ST_GRANT) data_q <= b.data_in[sel];
      if (state == ST_GRANT && nxt == ST_GAP) ptr <= sel + 1'b1;
      // a release on the timeout edge counts as normal, so only flag when req is still held
      tmo <= state == ST_GRANT && b.req[sel] && hold_hit;
    end
  always_comb begin
    b.busy = state == ST_GRANT;
    b.gnt = state == ST_GRANT ? NUM_REQ'(1) << sel : '0;
  end
  assign b.sel = sel;
  assign b.data_o = data_q;
  assign b.tmo_o = tmo;
endmodule
